timer_dev: RTL

- Memory-mapped programmable countdown timer on the CPU's processor bridge, acting as the responder to the core's PrAddr/PrBe/PrWD/PrRD bus.
- Generates one of the core's HWInt[7:2] interrupt lines.
- The bridge decodes the device base address and drives this block's local word address, write strobe, byte enables and write data.
- The block returns read data combinationally in the same cycle.

---
 rtl/timer_dev.sv | 128 ++++++++++++
 1 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the processor bridge.
// Supports one-shot and auto-reload modes, with a maskable interrupt line.
module timer_dev #(
   parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [3:0]  BE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      CNT  = 2'b10,
      INT  = 2'b11
   } state_t;

   state_t      state_r, state_s;
   logic [3:0]  ctrl_r, ctrl_s, ctrl_fsm_s;
   logic [31:0] preset_r, preset_s;
   logic [31:0] count_r, count_s;
   logic        irq_flag_r, irq_flag_s;
   logic        wr_ctrl_s, wr_preset_s, cpu_clr_s;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   assign wr_ctrl_s   = WE & (Addr == 2'd0);
   assign wr_preset_s = WE & (Addr == 2'd1);
   assign cpu_clr_s   = (wr_ctrl_s | wr_preset_s) & (BE != 4'b0000);

   // Next-state logic: timer sequencing first, then CPU writes override CTRL/PRESET.
   always_comb begin
      state_s    = state_r;
      count_s    = count_r;
      ctrl_fsm_s = ctrl_r;
      ctrl_s     = ctrl_r;
      preset_s   = preset_r;
      // A CPU write acknowledges the interrupt, but a same-cycle expiry still wins.
      if (cpu_clr_s) irq_flag_s = 1'b0;
      else           irq_flag_s = irq_flag_r;

      case (state_r)
         IDLE: begin
            if (ctrl_r[0]) state_s = LOAD;
            else           state_s = IDLE;
         end
         LOAD: begin
            if (ctrl_r[0]) begin
               count_s = preset_r;
               state_s = CNT;
            end else begin
               state_s = IDLE;
            end
         end
         CNT: begin
            if (!ctrl_r[0]) begin
               state_s = IDLE;
            end else if (count_r > 32'd1) begin
               count_s = count_r - 32'd1;
            end else begin
               count_s    = 32'd0;
               irq_flag_s = 1'b1;
               state_s    = INT;
            end
         end
         INT: begin
            if (ctrl_r[2:1] == 2'b01) begin
               irq_flag_s = 1'b0;
               state_s    = LOAD;
            end else begin
               ctrl_fsm_s = {ctrl_r[3:1], 1'b0};
               state_s    = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      if (wr_ctrl_s && BE[0]) ctrl_s = Din[3:0];
      else                    ctrl_s = ctrl_fsm_s;

      if (wr_preset_s) preset_s = merge_bytes(preset_r, Din, BE);
      else             preset_s = preset_r;
   end

   // State and register file update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         ctrl_r     <= 4'b0000;
         preset_r   <= PRESET_RST;
         count_r    <= 32'd0;
         irq_flag_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         ctrl_r     <= ctrl_s;
         preset_r   <= preset_s;
         count_r    <= count_s;
         irq_flag_r <= irq_flag_s;
      end
   end

   // Read mux, same-cycle response to the bridge.
   always_comb begin
      Dout = 32'd0;
      case (Addr)
         2'd0:    Dout = {28'd0, ctrl_r};
         2'd1:    Dout = preset_r;
         2'd2:    Dout = count_r;
         default: Dout = 32'd0;
      endcase
   end

   assign IRQ = ctrl_r[3] & irq_flag_r;

endmodule
